// File: rtl/vga_arb_pkg.sv
// Shared constants and FSM encoding for the pixel memory arbiter.
package vga_arb_pkg;

    localparam int unsigned NREQ_DEF   = 4;
    localparam int unsigned AW_DEF     = 17;
    localparam int unsigned DW_DEF     = 12;
    localparam int unsigned RD_LAT_DEF = 2;

    typedef enum logic [1:0] {
        SCAN  = 2'd0,
        DRAIN = 2'd1,
        BLANK = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first asserted request at or after rr_ptr, wrapping.
module rr_arbiter
    import vga_arb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] rr_ptr,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] idx
);

    localparam int unsigned IW = $clog2(NREQ);

    logic [IW-1:0] j;
    logic          found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            j = IW'((32'(rr_ptr) + off) % NREQ);
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = j;
            end
        end
    end

endmodule

// File: rtl/pix_mem_arbiter.sv
// Single-port pixel memory arbiter: reads while scanning, writes only during blanking.
// Optional ARB_STATS_EN adds the stall_cnt/stall_last read-stall statistics.
module pix_mem_arbiter
    import vga_arb_pkg::*;
#(
    parameter int unsigned NREQ   = NREQ_DEF,
    parameter int unsigned AW     = AW_DEF,
    parameter int unsigned DW     = DW_DEF,
    parameter int unsigned RD_LAT = RD_LAT_DEF
) (
    input  logic                    pclk,
    input  logic                    reset,
    input  logic                    frame_blank,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*AW-1:0]      req_addr,
    output logic [NREQ-1:0]         gnt,
    input  logic                    wr_req,
    input  logic [AW-1:0]           wr_addr,
    input  logic [DW-1:0]           wr_data,
    output logic                    wr_gnt,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [AW-1:0]           mem_addr,
    output logic [DW-1:0]           mem_wdata,
    input  logic [DW-1:0]           mem_rdata,
    output logic                    rvalid,
    output logic [$clog2(NREQ)-1:0] rid,
    output logic [DW-1:0]           rdata,
    output logic [1:0]              state
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]             stall_cnt,
    output logic [15:0]             stall_last
`endif
);

    localparam int unsigned IW = $clog2(NREQ);

    arb_state_t                   cur_st;
    logic [IW-1:0]                rr_ptr;
    logic [RD_LAT-1:0]            tag_vld;
    logic [RD_LAT-1:0][IW-1:0]    tag_id;
    logic [NREQ-1:0]              arb_req;
    logic [NREQ-1:0]              arb_gnt;
    logic [IW-1:0]                arb_idx;
    logic                         wr_fire;
    logic                         rd_ok;
    logic                         rd_fire;
    logic                         pipe_empty;

    // Reads are held off in the SCAN cycle that sees blanking so DRAIN is bounded by RD_LAT.
    always_comb begin
        wr_fire = !reset && (cur_st == BLANK) && frame_blank && wr_req;
        rd_ok   = !reset && (((cur_st == SCAN) && !frame_blank) ||
                             ((cur_st == BLANK) && !wr_fire));
    end

    assign arb_req    = rd_ok ? req : '0;
    assign rd_fire    = |arb_gnt;
    assign pipe_empty = (tag_vld == '0);

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req    (arb_req),
        .rr_ptr (rr_ptr),
        .gnt    (arb_gnt),
        .idx    (arb_idx)
    );

    assign gnt       = arb_gnt;
    assign wr_gnt    = wr_fire;
    assign mem_en    = wr_fire | rd_fire;
    assign mem_we    = wr_fire;
    assign mem_addr  = wr_fire ? wr_addr :
                       (rd_fire ? req_addr[32'(arb_idx) * AW +: AW] : '0);
    assign mem_wdata = wr_fire ? wr_data : '0;

    assign rvalid = !reset && tag_vld[RD_LAT-1];
    assign rid    = rvalid ? tag_id[RD_LAT-1] : '0;
    assign rdata  = rvalid ? mem_rdata : '0;
    assign state  = cur_st;

    // FSM, round-robin pointer and read-tag pipeline.
    always_ff @(posedge pclk) begin
        if (reset) begin
            cur_st  <= SCAN;
            rr_ptr  <= '0;
            tag_vld <= '0;
            tag_id  <= '0;
        end else begin
            case (cur_st)
                SCAN:    if (frame_blank) cur_st <= DRAIN;
                DRAIN:   if (pipe_empty) cur_st <= frame_blank ? BLANK : SCAN;
                BLANK:   if (!frame_blank) cur_st <= SCAN;
                default: cur_st <= SCAN;
            endcase
            if (rd_fire) begin
                rr_ptr <= (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
            end
            tag_vld[0] <= rd_fire;
            tag_id[0]  <= arb_idx;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_id[i]  <= tag_id[i-1];
            end
        end
    end

`ifdef ARB_STATS_EN
    logic stall_now;

    assign stall_now = (cur_st == SCAN) && ((req & ~arb_gnt) != '0);

    // Saturating stall counter, snapshotted when the frame enters blanking.
    always_ff @(posedge pclk) begin
        if (reset) begin
            stall_cnt  <= '0;
            stall_last <= '0;
        end else if ((cur_st == SCAN) && frame_blank) begin
            stall_last <= stall_cnt;
            stall_cnt  <= '0;
        end else if (stall_now && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/pix_mem_arbiter.md
PIX_MEM_ARBITER -- requirements
Module: pix_mem_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of pixel-fetch requesters (sprite/background layers).
REQ-002 Parameter AW, default 17, memory address width.
REQ-003 Parameter DW, default 12, memory data width (RGB444).
REQ-004 Parameter RD_LAT, default 2, memory read latency in pclk cycles (1..4).
REQ-005 pclk  in  1  pixel clock; reset  in  1  reset, synchronous, active-high.
REQ-006 frame_blank  in  1  high during vertical blanking; comes from the VGA timing block.
REQ-007 req  in  NREQ  per-requester read request, level, held until granted.
REQ-008 req_addr  in  NREQ*AW  packed read addresses; requester i uses bits [i*AW +: AW].
REQ-009 gnt  out  NREQ  one-hot read grant, one pclk cycle per granted request.
REQ-010 wr_req  in  1  game-logic write request; wr_addr  in  AW; wr_data  in  DW.
REQ-011 wr_gnt  out  1  write accepted this cycle.
REQ-012 mem_en  out  1; mem_we  out  1; mem_addr  out  AW; mem_wdata  out  DW: single-port memory command.
REQ-013 mem_rdata  in  DW  memory read data, valid RD_LAT cycles after mem_en with mem_we=0.
REQ-014 rvalid  out  1; rid  out  clog2(NREQ); rdata  out  DW: read return, tagged with the requester.
REQ-015 state  out  2  current FSM state, for debug.

Function
REQ-016 The FSM SHALL have states SCAN=0, DRAIN=1, BLANK=2.
REQ-017 SCAN: grant at most one req per cycle, round-robin starting at rr_ptr; writes never granted.
REQ-018 After a grant to index k, rr_ptr SHALL become (k+1) mod NREQ; with no grant, rr_ptr holds.
REQ-019 A grant SHALL drive gnt[k]=1, mem_en=1, mem_we=0, and mem_addr=req_addr[k] in the same cycle (combinational from registered state and inputs).
REQ-020 rvalid SHALL assert exactly RD_LAT cycles after each read grant, with rid=k and rdata=mem_rdata; returns stay in grant order via an RD_LAT-deep tag shift register.
REQ-021 SCAN->DRAIN when frame_blank=1; no new reads are granted in DRAIN.
REQ-022 DRAIN->BLANK when the tag pipeline is empty, at most RD_LAT cycles later; if none are in flight, DRAIN lasts one cycle.
REQ-023 BLANK: wr_req has priority; wr_gnt=1, mem_en=1, mem_we=1, addr/data passed through; otherwise reads are granted round-robin as in SCAN.
REQ-024 BLANK->SCAN when frame_blank=0; a write requested in that same cycle SHALL NOT be granted.
REQ-025 DRAIN with frame_blank=0 SHALL return to SCAN once the pipeline is empty.
REQ-026 A read or write command that is not granted SHALL NOT change memory; only grants SHALL touch mem_*.

Reset
REQ-027 On reset: state=SCAN, rr_ptr=0, tag pipeline cleared, gnt=0, wr_gnt=0, mem_en=0, mem_we=0, rvalid=0, rid=0, rdata=0.
REQ-028 Reset mid-read SHALL discard in-flight returns; no rvalid SHALL follow reset.

Configuration
REQ-029 With ARB_STATS_EN defined: output stall_cnt[15:0] counts cycles in SCAN where req!=0 and some req bit is not granted; it saturates at 0xFFFF, clears on reset, and latches into stall_last[15:0] then clears when SCAN->DRAIN.
REQ-030 Without ARB_STATS_EN, stall_cnt and stall_last SHALL be absent and no counter logic SHALL exist.

Structure
REQ-031 Package vga_arb_pkg SHALL hold the state encoding (SCAN/DRAIN/BLANK) and the default NREQ/AW/DW/RD_LAT constants.
REQ-032 The round-robin pick SHALL be the sub-module rr_arbiter (inputs: req, rr_ptr; outputs: one-hot gnt, index).

Verification
REQ-033 SCAN, req=4'b1111 held 8 cycles -> grants in order 0,1,2,3,0,1,2,3; rvalid at cycles 3..10 with rid matching (RD_LAT=2).
REQ-034 SCAN, wr_req=1 for 20 cycles -> wr_gnt stays 0 and mem_we stays 0 throughout.
REQ-035 Grant to req 2 in the cycle before frame_blank rises -> DRAIN for 2 cycles, rvalid rid=2 delivered, then BLANK; a pending wr_req is granted on the first BLANK cycle.
REQ-036 BLANK, wr_req=1 and req=4'b0001 together -> wr_gnt=1, gnt=0; when wr_req drops, gnt[0]=1 next cycle.
REQ-037 Reset asserted 1 cycle after a read grant -> no rvalid in the following 4 cycles; all outputs at reset values.
REQ-038 With ARB_STATS_EN: req=4'b0011 for 10 SCAN cycles, then frame_blank=1 -> stall_last=10 and stall_cnt=0.
